// File: rtl/sbox_arbiter.sv
// Shared byte-serial AES S-box engine arbitrating between the round datapath and the key scheduler.
// Define SBOX_ARB_RR_EN for round-robin tie breaking; otherwise the key scheduler has fixed priority.
module sbox_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_req,
    input  logic [127:0] st_in,
    output logic         st_ack,
    output logic         st_done,
    output logic [127:0] st_out,
    input  logic         ks_req,
    input  logic [31:0]  ks_in,
    output logic         ks_ack,
    output logic         ks_done,
    output logic [31:0]  ks_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [127:0]   work_q, work_d;
    logic [127:0]   res_q, res_d;
    logic [127:0]   st_out_q, st_out_d;
    logic [31:0]    ks_out_q, ks_out_d;
    logic           st_ack_q, st_ack_d;
    logic           ks_ack_q, ks_ack_d;
    logic           st_done_q, st_done_d;
    logic           ks_done_q, ks_done_d;
    logic           busy_q, busy_d;
    logic           grant_ks_s;
    logic           last_s;
    logic [7:0]     sub_s;
    logic [127:0]   res_shift_s;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = b[i] ? (p ^ aa) : p;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), followed by the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t2, t3, t6, t7, t14, t15, t30, t31, t62, t63, t126, t127, inv;
        t2   = gf_mul(x, x);
        t3   = gf_mul(t2, x);
        t6   = gf_mul(t3, t3);
        t7   = gf_mul(t6, x);
        t14  = gf_mul(t7, t7);
        t15  = gf_mul(t14, x);
        t30  = gf_mul(t15, t15);
        t31  = gf_mul(t30, x);
        t62  = gf_mul(t31, t31);
        t63  = gf_mul(t62, x);
        t126 = gf_mul(t63, t63);
        t127 = gf_mul(t126, x);
        inv  = gf_mul(t127, t127);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

`ifdef SBOX_ARB_RR_EN
    logic last_q, last_d;
    assign grant_ks_s = ks_req & (~st_req | ~last_q);
`else
    assign grant_ks_s = ks_req;
`endif

    assign sub_s       = sbox(work_q[7:0]);
    assign last_s      = owner_q ? (cnt_q == 5'd3) : (cnt_q == 5'd15);
    assign res_shift_s = owner_q ? {96'd0, sub_s, res_q[31:8]} : {sub_s, res_q[127:8]};

    // Next-state and next-output computation for the arbiter/substitution FSM.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        res_d     = res_q;
        st_out_d  = st_out_q;
        ks_out_d  = ks_out_q;
        st_ack_d  = 1'b0;
        ks_ack_d  = 1'b0;
        st_done_d = 1'b0;
        ks_done_d = 1'b0;
        busy_d    = busy_q;
`ifdef SBOX_ARB_RR_EN
        last_d    = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (st_req || ks_req) begin
                    state_d = S_SUB;
                    busy_d  = 1'b1;
                    cnt_d   = 5'd0;
                    res_d   = 128'd0;
                    owner_d = grant_ks_s;
`ifdef SBOX_ARB_RR_EN
                    last_d  = grant_ks_s;
`endif
                    if (grant_ks_s) begin
                        work_d   = {96'd0, ks_in};
                        ks_ack_d = 1'b1;
                    end else begin
                        work_d   = st_in;
                        st_ack_d = 1'b1;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_SUB: begin
                work_d = {8'h00, work_q[127:8]};
                res_d  = res_shift_s;
                cnt_d  = cnt_q + 5'd1;
                if (last_s) begin
                    // Outputs are registered on entry to DONE so they are valid during DONE.
                    state_d = S_DONE;
                    if (owner_q) begin
                        ks_out_d  = res_shift_s[31:0];
                        ks_done_d = 1'b1;
                    end else begin
                        st_out_d  = res_shift_s;
                        st_done_d = 1'b1;
                    end
                end else begin
                    state_d = S_SUB;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            cnt_q     <= 5'd0;
            work_q    <= 128'd0;
            res_q     <= 128'd0;
            st_out_q  <= 128'd0;
            ks_out_q  <= 32'd0;
            st_ack_q  <= 1'b0;
            ks_ack_q  <= 1'b0;
            st_done_q <= 1'b0;
            ks_done_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SBOX_ARB_RR_EN
            last_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            res_q     <= res_d;
            st_out_q  <= st_out_d;
            ks_out_q  <= ks_out_d;
            st_ack_q  <= st_ack_d;
            ks_ack_q  <= ks_ack_d;
            st_done_q <= st_done_d;
            ks_done_q <= ks_done_d;
            busy_q    <= busy_d;
`ifdef SBOX_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign st_ack  = st_ack_q;
    assign ks_ack  = ks_ack_q;
    assign st_done = st_done_q;
    assign ks_done = ks_done_q;
    assign st_out  = st_out_q;
    assign ks_out  = ks_out_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_sbox_arbiter.sv
// Directed self-checking bench for sbox_arbiter: timing, arbitration, reset abort and full S-box sweep.
module tb_sbox_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         st_req, ks_req;
    logic [127:0] st_in;
    logic [31:0]  ks_in;
    logic         st_ack, st_done, ks_ack, ks_done, busy;
    logic [127:0] st_out;
    logic [31:0]  ks_out;

    int err_cnt = 0;
    int chk_cnt = 0;

    int st_ack_at, st_done_at, ks_ack_at, ks_done_at, st_done_n, ks_done_n;
    logic excl_bad;
    logic [127:0] st_seen;
    logic [31:0]  ks_seen;

    logic [7:0] sbox_tab [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    sbox_arbiter dut (
        .clk(clk), .rst(rst),
        .st_req(st_req), .st_in(st_in), .st_ack(st_ack), .st_done(st_done), .st_out(st_out),
        .ks_req(ks_req), .ks_in(ks_in), .ks_ack(ks_ack), .ks_done(ks_done), .ks_out(ks_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = sbox_tab[w[8*j +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[8*j +: 8] = sbox_tab[s[8*j +: 8]];
        return r;
    endfunction

    task automatic clear_obs();
        st_ack_at = -1; st_done_at = -1; ks_ack_at = -1; ks_done_at = -1;
        st_done_n = 0; ks_done_n = 0; excl_bad = 1'b0;
        st_seen = 128'd0; ks_seen = 32'd0;
    endtask

    // Observe cycles first..first+n-1 after the sampling cycle; requesters drop req in their done cycle.
    task automatic watch(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            @(negedge clk);
            if ((st_ack && ks_ack) || (st_done && ks_done)) excl_bad = 1'b1;
            if (st_ack && st_ack_at < 0) st_ack_at = i;
            if (ks_ack && ks_ack_at < 0) ks_ack_at = i;
            if (st_done) begin
                st_done_n++;
                if (st_done_at < 0) st_done_at = i;
                st_seen = st_out;
                st_req  = 1'b0;
            end
            if (ks_done) begin
                ks_done_n++;
                if (ks_done_at < 0) ks_done_at = i;
                ks_seen = ks_out;
                ks_req  = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; st_req = 1'b0; ks_req = 1'b0; st_in = 128'd0; ks_in = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_cnt++; if ({st_ack, ks_ack, st_done, ks_done, busy} !== 5'b00000) begin err_cnt++; $display("FAIL reset_flags: got %b expected 00000", {st_ack, ks_ack, st_done, ks_done, busy}); end
        chk_cnt++; if (st_out !== 128'd0) begin err_cnt++; $display("FAIL reset_st_out: got %h expected 0", st_out); end
        chk_cnt++; if (ks_out !== 32'd0) begin err_cnt++; $display("FAIL reset_ks_out: got %h expected 0", ks_out); end
    endtask

    task automatic test_state();
        clear_obs();
        st_in = 128'h00112233445566778899aabbccddeeff; st_req = 1'b1;
        watch(1, 20);
        chk_cnt++; if (st_ack_at !== 1) begin err_cnt++; $display("FAIL st_ack_cycle: got %0d expected 1", st_ack_at); end
        chk_cnt++; if (st_done_at !== 17) begin err_cnt++; $display("FAIL st_done_cycle: got %0d expected 17", st_done_at); end
        chk_cnt++; if (st_seen !== 128'h638293c31bfc33f5c4eeacea4bc12816) begin err_cnt++; $display("FAIL st_value: got %h expected 638293c31bfc33f5c4eeacea4bc12816", st_seen); end
        chk_cnt++; if (st_done_n !== 1 || ks_ack_at !== -1) begin err_cnt++; $display("FAIL st_pulses: got done_n=%0d ks_ack=%0d expected 1/-1", st_done_n, ks_ack_at); end
        chk_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL st_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_ks();
        clear_obs();
        ks_in = 32'h09cf4f3c; ks_req = 1'b1;
        watch(1, 8);
        chk_cnt++; if (ks_ack_at !== 1) begin err_cnt++; $display("FAIL ks_ack_cycle: got %0d expected 1", ks_ack_at); end
        chk_cnt++; if (ks_done_at !== 5) begin err_cnt++; $display("FAIL ks_done_cycle: got %0d expected 5", ks_done_at); end
        chk_cnt++; if (ks_seen !== 32'h018a84eb) begin err_cnt++; $display("FAIL ks_value: got %h expected 018a84eb", ks_seen); end
        chk_cnt++; if (st_out !== 128'h638293c31bfc33f5c4eeacea4bc12816) begin err_cnt++; $display("FAIL ks_st_hold: got %h expected 638293c31bfc33f5c4eeacea4bc12816", st_out); end
    endtask

    task automatic test_back_to_back();
        int a1, a2, d1, d2;
        logic [31:0] o1, o2;
        a1 = -1; a2 = -1; d1 = -1; d2 = -1; o1 = 32'd0; o2 = 32'd0;
        ks_in = 32'h00000000; ks_req = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ks_ack) begin if (a1 < 0) a1 = i; else a2 = i; end
            if (ks_done) begin
                if (d1 < 0) begin d1 = i; o1 = ks_out; end
                else begin d2 = i; o2 = ks_out; ks_req = 1'b0; end
            end
            if (i == 1) ks_in = 32'h01010101;
        end
        chk_cnt++; if (a1 !== 1 || a2 !== 7) begin err_cnt++; $display("FAIL b2b_ack: got %0d,%0d expected 1,7", a1, a2); end
        chk_cnt++; if (d1 !== 5 || d2 !== 11) begin err_cnt++; $display("FAIL b2b_done: got %0d,%0d expected 5,11", d1, d2); end
        chk_cnt++; if (o1 !== 32'h63636363 || o2 !== 32'h7c7c7c7c) begin err_cnt++; $display("FAIL b2b_value: got %h,%h expected 63636363,7c7c7c7c", o1, o2); end
    endtask

    task automatic test_tie(input logic [127:0] s, input logic [31:0] w);
        clear_obs();
        st_in = s; ks_in = w; st_req = 1'b1; ks_req = 1'b1;
        watch(1, 25);
        chk_cnt++; if (ks_ack_at !== 1 || ks_done_at !== 5) begin err_cnt++; $display("FAIL tie_ks_timing: got ack=%0d done=%0d expected 1/5", ks_ack_at, ks_done_at); end
        chk_cnt++; if (st_ack_at !== 7 || st_done_at !== 23) begin err_cnt++; $display("FAIL tie_st_timing: got ack=%0d done=%0d expected 7/23", st_ack_at, st_done_at); end
        chk_cnt++; if (ks_seen !== sub_word(w) || st_seen !== sub_state(s)) begin err_cnt++; $display("FAIL tie_values: got %h %h expected %h %h", ks_seen, st_seen, sub_word(w), sub_state(s)); end
        chk_cnt++; if (excl_bad !== 1'b0) begin err_cnt++; $display("FAIL tie_exclusive: got %b expected 0", excl_bad); end
    endtask

    task automatic test_late_ks();
        clear_obs();
        st_in = 128'hffeeddccbbaa99887766554433221100; st_req = 1'b1;
        watch(1, 3);
        ks_in = 32'hdeadbeef; ks_req = 1'b1;
        watch(4, 22);
        chk_cnt++; if (st_done_at !== 17 || st_seen !== sub_state(128'hffeeddccbbaa99887766554433221100)) begin err_cnt++; $display("FAIL late_st: got done=%0d val=%h", st_done_at, st_seen); end
        chk_cnt++; if (ks_ack_at !== 19 || ks_done_at !== 23) begin err_cnt++; $display("FAIL late_ks_timing: got ack=%0d done=%0d expected 19/23", ks_ack_at, ks_done_at); end
        chk_cnt++; if (ks_seen !== sub_word(32'hdeadbeef)) begin err_cnt++; $display("FAIL late_ks_value: got %h expected %h", ks_seen, sub_word(32'hdeadbeef)); end
    endtask

    task automatic test_rst_mid();
        clear_obs();
        st_in = 128'h0123456789abcdef0123456789abcdef; st_req = 1'b1;
        watch(1, 8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_cnt++; if (busy !== 1'b0 || st_done !== 1'b0 || st_done_n !== 0) begin err_cnt++; $display("FAIL rst_abort_flags: got busy=%b done=%b n=%0d expected 0", busy, st_done, st_done_n); end
        chk_cnt++; if (st_out !== 128'd0 || ks_out !== 32'd0) begin err_cnt++; $display("FAIL rst_abort_outs: got %h %h expected 0", st_out, ks_out); end
        clear_obs();
        st_in = 128'h53535353535353535353535353535353;
        watch(1, 18);
        chk_cnt++; if (st_ack_at !== 1 || st_done_at !== 17) begin err_cnt++; $display("FAIL rst_rereq_timing: got ack=%0d done=%0d expected 1/17", st_ack_at, st_done_at); end
        chk_cnt++; if (st_seen !== 128'hedededededededededededededededed) begin err_cnt++; $display("FAIL rst_rereq_value: got %h expected all ed", st_seen); end
    endtask

    task automatic test_sweep();
        logic [31:0] w;
        for (int i = 0; i < 64; i++) begin
            w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            clear_obs();
            ks_in = w; ks_req = 1'b1;
            watch(1, 6);
            chk_cnt++; if (ks_done_at !== 5 || ks_seen !== sub_word(w)) begin err_cnt++; $display("FAIL sweep_%0d: got done=%0d val=%h expected 5 %h", i, ks_done_at, ks_seen, sub_word(w)); end
        end
    endtask

    initial begin
        test_reset();
        test_state();
        test_ks();
        test_back_to_back();
        repeat (2) @(negedge clk);
        test_tie(128'h0102030405060708090a0b0c0d0e0f10, 32'h53535353);
        test_tie(128'h00000000ffffffff1111111122222222, 32'hc0ffee00);
        test_late_ks();
        test_rst_mid();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
